pll_mgr: RTL and testbench
==========================

# pll_mgr

Parametrised PLL manager that runs in the board reference-clock domain and owns the dynamic divider inputs, reset pin and lock output of one rPLL primitive. It sequences PLL reset, qualifies lock, releases NUM_RST downstream domain resets in staggered order, and recovers automatically from lock loss or lock timeout. A valid/ready request retunes the PLL at run time, e.g. switching the video/system clock between modes, without a bitstream rebuild.

## Interface
- NUM_RST, 2: number of downstream active-low domain resets
- RST_CYCLES, 16: cycles pll_reset is held high per reset attempt
- LOCK_STABLE, 1024: consecutive synced-lock cycles required before release
- LOCK_TIMEOUT, 65536: cycles in WAIT_LOCK before a fresh reset attempt
- RST_STAGGER, 16: cycles between successive domain-reset releases
- DEF_IDSEL / DEF_FBDSEL / DEF_ODSEL, 6'd55 / 6'd11 / pll_mgr_pkg::odsel_code(4): power-on divider codes
- clk  in  1  reference clock, PLL input clock
- reset_n  in  1  asynchronous active-low reset
- pll_lock  in  1  raw PLL LOCK, asynchronous to clk
- pll_reset  out  1  to rPLL RESET
- pll_idsel / pll_fbdsel / pll_odsel  out  6 each  to rPLL IDSEL/FBDSEL/ODSEL
- cfg_valid  in  1  retune request
- cfg_ready  out  1  request accepted when valid && ready
- cfg_idsel / cfg_fbdsel / cfg_odsel  in  6 each  new raw codes
- rst_n_o  out  NUM_RST  domain resets; bit 0 released first
- locked  out  1  high only in RUN
- loss_cnt  out  8  lock-loss event count

## Operation
- Reset values: pll_reset=1, sel outputs = DEF_*, rst_n_o=0, locked=0, cfg_ready=0, loss_cnt=0, state=PLL_RST, counter=0.
- pll_lock passes a 2-FF synchroniser before any use, giving lock_s.
- PLL_RST: pll_reset=1, all rst_n_o=0. After RST_CYCLES cycles, go to WAIT_LOCK and set pll_reset=0.
- WAIT_LOCK: lock_s=1 moves to STABLE with counter cleared. LOCK_TIMEOUT cycles without lock moves to PLL_RST.
- STABLE: counts consecutive lock_s=1. lock_s=0 returns to WAIT_LOCK. At LOCK_STABLE, go to RELEASE.
- RELEASE: rst_n_o[i] goes high at cycle i*RST_STAGGER after entry. The cycle after rst_n_o[NUM_RST-1] rises, go to RUN.
- RUN: locked=1, cfg_ready=1.
- Lock loss: lock_s=0 in RELEASE or RUN sets all rst_n_o=0 and locked=0 on the next edge, and returns to WAIT_LOCK. pll_reset is not pulsed.
- Retune: a handshake in RUN latches cfg_* into pll_*sel, drops all rst_n_o and locked on the same edge, and goes to PLL_RST. cfg_ready is low outside RUN, so requests wait.
- A handshake and lock loss in the same cycle: the retune wins, the new codes are applied, and loss_cnt is still incremented.
- Asserting reset_n mid-sequence restores all reset values, including the DEF_* codes. Any retuned codes are discarded.

## Timing
- Lock qualification latency from a pll_lock rising edge: 2 sync cycles, then LOCK_STABLE cycles, then entry to RELEASE.
- Lock-loss reaction: 3 cycles from pll_lock falling to all rst_n_o low (2 sync + 1 register).
- Retune: rst_n_o low 1 cycle after the handshake edge; pll_reset high for exactly RST_CYCLES.
- All outputs are registered; no combinational path from input to output.
- Counter width is clog2(max(LOCK_TIMEOUT, LOCK_STABLE, NUM_RST*RST_STAGGER)+1).

## Configuration
- PLL_MGR_LOSS_CNT_EN defined: loss_cnt increments by 1, saturating at 255, on each lock loss seen in RELEASE or RUN. It clears only on reset_n.
- PLL_MGR_LOSS_CNT_EN undefined: loss_cnt is tied to 8'd0 and the counter logic is absent. The port always exists.

## Structure
- pll_mgr_pkg holds:
  - the state enum (PLL_RST, WAIT_LOCK, STABLE, RELEASE, RUN);
  - the idsel/fbdsel helpers (63 - divider setting);
  - odsel_code(divider).
- One sub-module, pll_mgr_sync: 2-FF synchroniser with asynchronous active-low reset, reset value 0.

## Test plan
- Power-on: reset_n released, pll_lock high at cycle 30 with parameters 16/1024/16.
  - pll_reset falls at cycle 16.
  - rst_n_o[0] rises at 30+2+1024 (±1 registered).
  - rst_n_o[1] rises 16 later; locked rises 1 after that.
- Glitchy lock: pll_lock drops for 1 cycle mid-STABLE → counter restarts; release is delayed by the glitch position plus the full LOCK_STABLE.
- Timeout: pll_lock held low → pll_reset re-pulses every RST_CYCLES+LOCK_TIMEOUT cycles; rst_n_o stay 0.
- Lock loss in RUN: pll_lock falls → all rst_n_o=0 in 3 cycles, loss_cnt=1 (0 without macro), recovery without a pll_reset pulse.
- Retune: cfg_fbdsel=6'd20 accepted in RUN → pll_fbdsel=20 the next cycle, pll_reset high for 16 cycles, full re-release; a second request during the sequence sees cfg_ready=0.
- Saturation: 300 loss events → loss_cnt=255.

Source files
------------

// File: rtl/pll_mgr_pkg.sv
// Shared types and divider-code helpers for the PLL manager.
package pll_mgr_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } pll_state_t;

    typedef struct packed {
        logic [5:0] idsel;
        logic [5:0] fbdsel;
        logic [5:0] odsel;
    } pll_div_t;

    // rPLL input/feedback dividers take the one's complement of the setting
    function automatic logic [5:0] idsel_code(input int setting);
        return 6'(63 - setting);
    endfunction

    function automatic logic [5:0] fbdsel_code(input int setting);
        return 6'(63 - setting);
    endfunction

    function automatic logic [5:0] odsel_code(input int div);
        logic [5:0] code;
        case (div)
            2:       code = 6'd62;
            4:       code = 6'd60;
            8:       code = 6'd56;
            16:      code = 6'd48;
            32:      code = 6'd32;
            48:      code = 6'd16;
            64:      code = 6'd0;
            default: code = 6'd60;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/pll_mgr_sync.sv
// Two-flop synchroniser for the raw PLL lock, resets to 0 (unlocked).
module pll_mgr_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_mgr.sv
// PLL reset/lock sequencer with staggered domain-reset release and run-time retune.
// Optional lock-loss counter enabled by defining PLL_MGR_LOSS_CNT_EN.
module pll_mgr
    import pll_mgr_pkg::*;
#(
    parameter int         NUM_RST      = 2,
    parameter int         RST_CYCLES   = 16,
    parameter int         LOCK_STABLE  = 1024,
    parameter int         LOCK_TIMEOUT = 65536,
    parameter int         RST_STAGGER  = 16,
    parameter logic [5:0] DEF_IDSEL    = 6'd55,
    parameter logic [5:0] DEF_FBDSEL   = 6'd11,
    parameter logic [5:0] DEF_ODSEL    = odsel_code(4)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               pll_lock,
    output logic               pll_reset,
    output logic [5:0]         pll_idsel,
    output logic [5:0]         pll_fbdsel,
    output logic [5:0]         pll_odsel,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [5:0]         cfg_idsel,
    input  logic [5:0]         cfg_fbdsel,
    input  logic [5:0]         cfg_odsel,
    output logic [NUM_RST-1:0] rst_n_o,
    output logic               locked,
    output logic [7:0]         loss_cnt
);

    localparam int REL_SPAN = NUM_RST * RST_STAGGER;
    localparam int CNT_MAX0 = (LOCK_TIMEOUT > LOCK_STABLE) ? LOCK_TIMEOUT : LOCK_STABLE;
    localparam int CNT_MAX  = (CNT_MAX0 > REL_SPAN) ? CNT_MAX0 : REL_SPAN;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam pll_div_t DEF_DIV = '{idsel: DEF_IDSEL, fbdsel: DEF_FBDSEL, odsel: DEF_ODSEL};

    pll_state_t state;
    logic [CNT_W-1:0] cnt;
    pll_div_t   div_q;
    logic       lock_s;

    pll_mgr_sync u_lock_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pll_lock),
        .q       (lock_s)
    );

    assign pll_idsel  = div_q.idsel;
    assign pll_fbdsel = div_q.fbdsel;
    assign pll_odsel  = div_q.odsel;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= PLL_RST;
            cnt       <= '0;
            pll_reset <= 1'b1;
            div_q     <= DEF_DIV;
            rst_n_o   <= '0;
            locked    <= 1'b0;
            cfg_ready <= 1'b0;
        end else begin
            case (state)
                PLL_RST: begin
                    if (cnt == CNT_W'(RST_CYCLES - 1)) begin
                        state     <= WAIT_LOCK;
                        pll_reset <= 1'b0;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        state     <= PLL_RST;
                        pll_reset <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == CNT_W'(LOCK_STABLE - 1)) begin
                        // domain 0 is released on the entry edge itself
                        state      <= RELEASE;
                        cnt        <= '0;
                        rst_n_o[0] <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (!lock_s) begin
                        state   <= WAIT_LOCK;
                        cnt     <= '0;
                        rst_n_o <= '0;
                        locked  <= 1'b0;
                    end else if (rst_n_o[NUM_RST-1]) begin
                        state     <= RUN;
                        locked    <= 1'b1;
                        cfg_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                        for (int i = 1; i < NUM_RST; i++)
                            if (cnt == CNT_W'(i * RST_STAGGER - 1))
                                rst_n_o[i] <= 1'b1;
                    end
                end
                RUN: begin
                    // retune outranks a simultaneous lock loss
                    if (cfg_valid && cfg_ready) begin
                        state     <= PLL_RST;
                        cnt       <= '0;
                        pll_reset <= 1'b1;
                        div_q     <= '{idsel: cfg_idsel, fbdsel: cfg_fbdsel, odsel: cfg_odsel};
                        rst_n_o   <= '0;
                        locked    <= 1'b0;
                        cfg_ready <= 1'b0;
                    end else if (!lock_s) begin
                        state     <= WAIT_LOCK;
                        cnt       <= '0;
                        rst_n_o   <= '0;
                        locked    <= 1'b0;
                        cfg_ready <= 1'b0;
                    end
                end
                default: begin
                    state     <= PLL_RST;
                    cnt       <= '0;
                    pll_reset <= 1'b1;
                    rst_n_o   <= '0;
                    locked    <= 1'b0;
                    cfg_ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef PLL_MGR_LOSS_CNT_EN
    logic       loss_evt;
    logic [7:0] loss_q;

    assign loss_evt = ((state == RELEASE) || (state == RUN)) && !lock_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            loss_q <= 8'd0;
        else if (loss_evt && (loss_q != 8'hFF))
            loss_q <= loss_q + 8'd1;
    end

    assign loss_cnt = loss_q;
`else
    assign loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_mgr.sv
// Directed bench for pll_mgr: power-on, glitch, loss, retune, timeout, saturation.
module tb_pll_mgr;
    import pll_mgr_pkg::*;

    localparam int NR  = 2;
    localparam int RC  = 16;
    localparam int LS  = 64;
    localparam int TO  = 256;
    localparam int STG = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          pll_lock = 1'b0;
    logic          pll_reset;
    logic [5:0]    pll_idsel, pll_fbdsel, pll_odsel;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [5:0]    cfg_idsel = 6'd0, cfg_fbdsel = 6'd0, cfg_odsel = 6'd0;
    logic [NR-1:0] rst_n_o;
    logic          locked;
    logic [7:0]    loss_cnt;

    int nvec = 0;
    int nmis = 0;

    pll_mgr #(
        .NUM_RST(NR), .RST_CYCLES(RC), .LOCK_STABLE(LS),
        .LOCK_TIMEOUT(TO), .RST_STAGGER(STG)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pll_lock(pll_lock), .pll_reset(pll_reset),
        .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel), .pll_odsel(pll_odsel),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idsel(cfg_idsel),
        .cfg_fbdsel(cfg_fbdsel), .cfg_odsel(cfg_odsel), .rst_n_o(rst_n_o),
        .locked(locked), .loss_cnt(loss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_loss(input int n);
`ifdef PLL_MGR_LOSS_CNT_EN
        return (n > 255) ? 255 : n;
`else
        return 0 * n;
`endif
    endfunction

    task automatic wait_locked(input int bound, output int n, output bit saw_rst);
        n = 0;
        saw_rst = 1'b0;
        while (!locked && n < bound) begin
            tick();
            n++;
            if (pll_reset) saw_rst = 1'b1;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n, t_rst, t_r0, t_r1, t_lk, t_g, hi, t_f1, t_rr, t_f2, bad, at254;
        bit  saw, rdy_seen, rst_seen;

        repeat (3) tick();
        chk("rst_pll_reset", pll_reset, 1);
        chk("rst_idsel", pll_idsel, 55);
        chk("rst_fbdsel", pll_fbdsel, 11);
        chk("rst_odsel", pll_odsel, 60);
        chk("rst_rst_n_o", rst_n_o, 0);
        chk("rst_locked", locked, 0);
        chk("rst_cfg_ready", cfg_ready, 0);
        chk("rst_loss_cnt", loss_cnt, 0);

        // power-on: lock seen by the first sync flop at edge 30
        reset_n = 1'b1;
        t_rst = 0; t_r0 = 0; t_r1 = 0; t_lk = 0;
        for (int c = 1; c <= 2000 && !locked; c++) begin
            if (c == 30) pll_lock = 1'b1;
            tick();
            if (!pll_reset && t_rst == 0) t_rst = c;
            if (rst_n_o[0] && t_r0 == 0) t_r0 = c;
            if (rst_n_o[1] && t_r1 == 0) t_r1 = c;
            if (locked && t_lk == 0) t_lk = c;
        end
        chk("pon_reset_fall", t_rst, RC);
        chk("pon_rst0_rise", t_r0, 30 + 2 + LS);
        chk("pon_rst1_rise", t_r1, 30 + 2 + LS + STG);
        chk("pon_locked", t_lk, 30 + 2 + LS + STG + 1);
        chk("pon_cfg_ready", cfg_ready, 1);

        // lock loss in RUN
        pll_lock = 1'b0;
        tick(); tick();
        chk("loss_pre_rst", rst_n_o, 2'b11);
        tick();
        chk("loss_rst_n_o", rst_n_o, 0);
        chk("loss_locked", locked, 0);
        chk("loss_cfg_ready", cfg_ready, 0);
        chk("loss_cnt1", loss_cnt, exp_loss(1));
        pll_lock = 1'b1;
        wait_locked(500, n, saw);
        chk("relock_cycles", n, 3 + LS + STG + 1);
        chk("relock_no_pll_reset", saw, 0);

        // one-cycle glitch mid-STABLE restarts qualification
        pll_lock = 1'b0;
        repeat (5) tick();
        chk("loss_cnt2", loss_cnt, exp_loss(2));
        pll_lock = 1'b1;
        t_g = 0;
        for (int c = 1; c <= 400 && !locked; c++) begin
            if (c == 21) pll_lock = 1'b0;
            if (c == 22) pll_lock = 1'b1;
            tick();
            if (rst_n_o[0] && t_g == 0) t_g = c;
        end
        chk("glitch_release", t_g, 24 + LS);
        chk("glitch_locked", locked, 1);
        chk("glitch_no_count", loss_cnt, exp_loss(2));

        // retune, with a second request held during the sequence
        cfg_idsel = 6'd50; cfg_fbdsel = 6'd20; cfg_odsel = 6'd56; cfg_valid = 1'b1;
        tick();
        chk("rt_fbdsel", pll_fbdsel, 20);
        chk("rt_idsel", pll_idsel, 50);
        chk("rt_odsel", pll_odsel, 56);
        chk("rt_rst_n_o", rst_n_o, 0);
        chk("rt_locked", locked, 0);
        chk("rt_pll_reset", pll_reset, 1);
        chk("rt_cfg_ready", cfg_ready, 0);
        cfg_fbdsel = 6'd33;
        hi = 1; rdy_seen = 1'b0;
        while (pll_reset && hi < 100) begin
            tick();
            hi++;
            if (cfg_ready) rdy_seen = 1'b1;
        end
        chk("rt_reset_width", hi - 1, RC);
        chk("rt_second_blocked", rdy_seen, 0);
        chk("rt_fbdsel_hold", pll_fbdsel, 20);
        cfg_valid = 1'b0;
        wait_locked(500, n, saw);
        chk("rt_relock_cycles", n, 1 + LS + STG + 1);
        chk("rt_relock_no_reset", saw, 0);

        // retune coinciding with lock loss
        pll_lock = 1'b0;
        tick(); tick();
        cfg_fbdsel = 6'd7; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("both_fbdsel", pll_fbdsel, 7);
        chk("both_pll_reset", pll_reset, 1);
        chk("both_rst_n_o", rst_n_o, 0);
        chk("both_loss_cnt", loss_cnt, exp_loss(3));

        // reset mid-sequence discards retuned codes
        repeat (4) tick();
        reset_n = 1'b0;
        tick();
        chk("mid_idsel", pll_idsel, 55);
        chk("mid_fbdsel", pll_fbdsel, 11);
        chk("mid_odsel", pll_odsel, 60);
        chk("mid_loss_cnt", loss_cnt, 0);
        chk("mid_pll_reset", pll_reset, 1);

        // timeout with lock held low
        reset_n = 1'b1;
        t_f1 = 0; t_rr = 0; t_f2 = 0; rst_seen = 1'b0;
        for (int c = 1; c <= 700 && t_f2 == 0; c++) begin
            tick();
            if (rst_n_o != 0) rst_seen = 1'b1;
            if (!pll_reset && t_f1 == 0) t_f1 = c;
            else if (pll_reset && t_f1 != 0 && t_rr == 0) t_rr = c;
            else if (!pll_reset && t_rr != 0 && t_f2 == 0) t_f2 = c;
        end
        chk("to_first_fall", t_f1, RC);
        chk("to_repulse", t_rr, RC + TO);
        chk("to_period", t_f2 - t_f1, RC + TO);
        chk("to_rst_n_o_low", rst_seen, 0);

        // saturation of the loss counter
        bad = 0; at254 = -1;
        for (int e = 1; e <= 300; e++) begin
            pll_lock = 1'b1;
            wait_locked(300, n, saw);
            if (!locked) bad++;
            pll_lock = 1'b0;
            repeat (3) tick();
            if (e == 254) at254 = int'(loss_cnt);
        end
        chk("sat_lock_fail", bad, 0);
        chk("sat_at_254", at254, exp_loss(254));
        chk("sat_loss_cnt", loss_cnt, exp_loss(300));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
